// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I multi-cycle control path and its datapath muxes.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package riscv_pkg;

  // Base opcodes inst[6:0]
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  // Controller state, also exported on the debug port
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  // PC next-value select
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_BTGT  = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  // Register write-back select
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  // ALU operand / operation selects
  localparam logic [1:0] SRCA_RS1  = 2'd0;
  localparam logic [1:0] SRCA_PC   = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;
  localparam logic       SRCB_RS2  = 1'b0;
  localparam logic       SRCB_IMM  = 1'b1;
  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_FUNCT  = 2'd1;
  localparam logic [1:0] ALU_BRANCH = 2'd2;

  // One-hot instruction class
  typedef struct packed {
    logic r_type;
    logic i_alu;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
    logic fence;
  } iclass_t;

endpackage

// File: rtl/riscv_opcode_decode.sv
// Maps an RV32I opcode to a one-hot instruction class and a legal flag.
// Latency: purely combinational.
// Backpressure: none.
module riscv_opcode_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    cls,
  output logic       legal
);

  // Opcode lookup; anything unlisted (SYSTEM included) leaves every class bit low
  always_comb begin
    cls = '0;
    case (opcode)
      OP_R:      cls.r_type = 1'b1;
      OP_IMM:    cls.i_alu  = 1'b1;
      OP_LOAD:   cls.load   = 1'b1;
      OP_STORE:  cls.store  = 1'b1;
      OP_BRANCH: cls.branch = 1'b1;
      OP_JAL:    cls.jal    = 1'b1;
      OP_JALR:   cls.jalr   = 1'b1;
      OP_LUI:    cls.lui    = 1'b1;
      OP_AUIPC:  cls.auipc  = 1'b1;
      OP_FENCE:  cls.fence  = 1'b1;
      default:   cls = '0;
    endcase
  end

  assign legal = (cls != '0);

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing with traps.
// Latency: 3-5 cycles per instruction with zero-wait memory, +1 per memReady wait cycle.
// Backpressure: stalls in FETCH/MEM until memReady; traps after MEM_TIMEOUT waiting cycles.
module riscv_multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        branchTaken,
  input  logic        memReady,
  output logic        memReq,
  output logic        memWe,
  output logic        memIsInstr,
  output logic        irWrite,
  output logic        pcWrite,
  output logic [1:0]  pcSel,
  output logic        regWrite,
  output logic [1:0]  wbSel,
  output logic [1:0]  aluSrcA,
  output logic        aluSrcB,
  output logic [1:0]  aluOp,
  output logic        instRetired,
  output logic        illegal,
  output logic        busErr,
  output logic [2:0]  state
);

  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_t          cur, nxt;
  logic [TMO_W-1:0] tmo;
  logic            illegal_q, bus_err_q;
  logic            set_ill, set_be;
  logic            req_state, tmo_expire;
  iclass_t         cls;
  logic            legal;
  logic            unused_inst_bits;

  assign unused_inst_bits = ^inst[31:7];

  riscv_opcode_decode u_dec (
    .opcode (inst[6:0]),
    .cls    (cls),
    .legal  (legal)
  );

  assign req_state  = (cur == ST_FETCH) || (cur == ST_MEM);
  // The counter holds the number of already-elapsed waiting cycles, so the
  // MEM_TIMEOUT-th waiting cycle is the one where it reads MEM_TIMEOUT-1.
  assign tmo_expire = (MEM_TIMEOUT != 0) && req_state && !memReady && (tmo == TMO_LAST);

  // State, timeout counter and sticky trap flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur       <= ST_IDLE;
      tmo       <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      cur <= nxt;
      // Any completed request or non-request state zeroes the counter, so it
      // is always zero on entry to FETCH or MEM; saturate when timeout is off.
      if (req_state && !memReady) begin
        if (tmo != '1) tmo <= tmo + 1'b1;
      end else begin
        tmo <= '0;
      end
      illegal_q <= illegal_q | set_ill;
      bus_err_q <= bus_err_q | set_be;
    end
  end

  // Next-state selection and trap cause detection
  always_comb begin
    nxt     = cur;
    set_ill = 1'b0;
    set_be  = 1'b0;
    case (cur)
      ST_IDLE:   nxt = ST_FETCH;
      ST_FETCH: begin
        if (memReady) nxt = ST_DECODE;
        else if (tmo_expire) begin
          nxt    = ST_TRAP;
          set_be = 1'b1;
        end
      end
      ST_DECODE: begin
        if (legal) nxt = ST_EXEC;
        else begin
          nxt     = ST_TRAP;
          set_ill = 1'b1;
        end
      end
      ST_EXEC: begin
        if (cls.load || cls.store) nxt = ST_MEM;
        else if (cls.branch || cls.jal || cls.jalr || cls.fence) nxt = ST_FETCH;
        else if (legal) nxt = ST_WB;
        else begin
          // IR cannot change after DECODE; kept as a safe fallback
          nxt     = ST_TRAP;
          set_ill = 1'b1;
        end
      end
      ST_MEM: begin
        if (memReady) nxt = cls.load ? ST_WB : ST_FETCH;
        else if (tmo_expire) begin
          nxt    = ST_TRAP;
          set_be = 1'b1;
        end
      end
      ST_WB:     nxt = ST_FETCH;
      ST_TRAP:   nxt = ST_TRAP;
      default:   nxt = ST_IDLE;
    endcase
  end

  // Datapath strobes and selects decoded from state, class and handshakes
  always_comb begin
    memReq      = 1'b0;
    memWe       = 1'b0;
    memIsInstr  = 1'b0;
    irWrite     = 1'b0;
    pcWrite     = 1'b0;
    pcSel       = PC_PLUS4;
    regWrite    = 1'b0;
    wbSel       = WB_ALU;
    aluSrcA     = SRCA_RS1;
    aluSrcB     = SRCB_RS2;
    aluOp       = ALU_ADD;
    instRetired = 1'b0;

    // The ALU is unregistered, so its selects stay put from EXEC through
    // MEM (address) and WB (result written back).
    if (cur == ST_EXEC || cur == ST_MEM || cur == ST_WB) begin
      if (cls.r_type) aluOp = ALU_FUNCT;
      if (cls.i_alu) begin
        aluSrcB = SRCB_IMM;
        aluOp   = ALU_FUNCT;
      end
      if (cls.auipc) begin
        aluSrcA = SRCA_PC;
        aluSrcB = SRCB_IMM;
      end
      if (cls.load || cls.store || cls.jalr) aluSrcB = SRCB_IMM;
      if (cls.branch) aluOp = ALU_BRANCH;
    end

    case (cur)
      ST_FETCH: begin
        memReq     = 1'b1;
        memIsInstr = 1'b1;
        irWrite    = memReady;
      end
      ST_EXEC: begin
        if (cls.branch) begin
          pcWrite     = 1'b1;
          pcSel       = branchTaken ? PC_BTGT : PC_PLUS4;
          instRetired = 1'b1;
        end
        if (cls.jal || cls.jalr) begin
          regWrite    = 1'b1;
          wbSel       = WB_PC4;
          pcWrite     = 1'b1;
          pcSel       = cls.jal ? PC_BTGT : PC_ALU;
          instRetired = 1'b1;
        end
        if (cls.fence) begin
          pcWrite     = 1'b1;
          instRetired = 1'b1;
        end
      end
      ST_MEM: begin
        memReq = 1'b1;
        memWe  = cls.store;
        if (memReady && cls.store) begin
          pcWrite     = 1'b1;
          instRetired = 1'b1;
        end
      end
      ST_WB: begin
        regWrite    = 1'b1;
        wbSel       = cls.load ? WB_MEM : (cls.lui ? WB_IMM : WB_ALU);
        pcWrite     = 1'b1;
        instRetired = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign busErr  = bus_err_q;
  assign state   = cur;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Self-checking bench for riscv_multicycle_ctrl: vector table, corner sequences, random program.
// Latency: n/a.
// Backpressure: memReady wait states driven by the bench.
module tb_riscv_multicycle_ctrl;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = 32'h0;
  logic        branchTaken = 1'b0;
  logic        memReady = 1'b0;
  logic        memReq, memWe, memIsInstr, irWrite, pcWrite, regWrite, aluSrcB;
  logic        instRetired, illegal, busErr;
  logic [1:0]  pcSel, wbSel, aluSrcA, aluOp;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  riscv_multicycle_ctrl #(.MEM_TIMEOUT(4), .TMO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .branchTaken(branchTaken),
    .memReady(memReady), .memReq(memReq), .memWe(memWe), .memIsInstr(memIsInstr),
    .irWrite(irWrite), .pcWrite(pcWrite), .pcSel(pcSel), .regWrite(regWrite),
    .wbSel(wbSel), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .instRetired(instRetired), .illegal(illegal), .busErr(busErr), .state(state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic req, we, isi, irw, pcw;
    logic [1:0] pcs;
    logic rw;
    logic [1:0] wbs, sa;
    logic sb;
    logic [1:0] op;
    logic ret, ill, be;
  } obs_t;

  typedef struct {
    logic        r;
    logic [31:0] i;
    logic        mr, bt;
    obs_t        e;
    string       nm;
  } vec_t;

  obs_t got;
  assign got = {state, memReq, memWe, memIsInstr, irWrite, pcWrite, pcSel, regWrite,
                wbSel, aluSrcA, aluSrcB, aluOp, instRetired, illegal, busErr};

  localparam logic [31:0] ADDI = 32'h00500093, LW = 32'h0000A103, SW = 32'h0020A023;
  localparam logic [31:0] BEQ = 32'h00208463, JALR = 32'h000080E7, LUI = 32'h123450B7;
  localparam logic [31:0] JAL = 32'h008000EF, BAD = 32'h0000007F;

  function automatic obs_t o(logic [2:0] st, logic req, logic we, logic isi, logic irw,
                             logic pcw, logic [1:0] pcs, logic rw, logic [1:0] wbs,
                             logic [1:0] sa, logic sb, logic [1:0] op, logic ret,
                             logic ill, logic be);
    return {st, req, we, isi, irw, pcw, pcs, rw, wbs, sa, sb, op, ret, ill, be};
  endfunction

  // Drive one cycle's inputs on the falling edge and compare settled outputs
  task automatic step(input logic r, input logic [31:0] i, input logic mr, input logic bt,
                      input obs_t e, input string nm);
    @(negedge clk);
    rst_n = r; inst = i; memReady = mr; branchTaken = bt;
    #1;
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h (state got %0d exp %0d)", nm, got, e, got.st, e.st);
    end
  endtask

  // One rising edge with reset low; the following step sees IDLE
  task automatic rst_pulse();
    @(negedge clk);
    rst_n = 1'b0; memReady = 1'b0;
  endtask

  vec_t tv[$];
  vec_t rq[$];

  task automatic addv(input logic r, input logic [31:0] i, input logic mr, input logic bt,
                      input obs_t e, input string nm);
    vec_t v;
    v.r = r; v.i = i; v.mr = mr; v.bt = bt; v.e = e; v.nm = nm;
    tv.push_back(v);
  endtask

  // Reference: expected per-cycle trace of one instruction from its class and wait counts
  task automatic plan(input logic [31:0] ins, input int fw, input int mw, input logic bt);
    vec_t v;
    logic [6:0] opc = ins[6:0];
    logic is_r  = (opc == 7'h33), is_i = (opc == 7'h13), is_ld = (opc == 7'h03);
    logic is_st = (opc == 7'h23), is_br = (opc == 7'h63), is_jal = (opc == 7'h6F);
    logic is_jr = (opc == 7'h67), is_lui = (opc == 7'h37), is_aui = (opc == 7'h17);
    logic is_fn = (opc == 7'h0F);
    logic [1:0] sa = is_aui ? 2'd1 : 2'd0;
    logic       sb = is_i | is_aui | is_ld | is_st | is_jr;
    logic [1:0] op = (is_r | is_i) ? 2'd1 : (is_br ? 2'd2 : 2'd0);
    v.r = 1'b1; v.i = ins; v.bt = bt;
    for (int k = 0; k <= fw; k++) begin
      v.mr = (k == fw); v.nm = "rnd_fetch";
      v.e = o(ST_FETCH, 1, 0, 1, (k == fw), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rq.push_back(v);
    end
    v.mr = 1'($urandom); v.nm = "rnd_decode";
    v.e = o(ST_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rq.push_back(v);
    v.nm = "rnd_exec";
    v.e = o(ST_EXEC, 0, 0, 0, 0, 0, 0, 0, 0, sa, sb, op, 0, 0, 0);
    if (is_br) begin v.e.pcw = 1; v.e.pcs = bt ? 2'd1 : 2'd0; v.e.ret = 1; end
    if (is_jal | is_jr) begin
      v.e.rw = 1; v.e.wbs = 2'd2; v.e.pcw = 1; v.e.pcs = is_jal ? 2'd1 : 2'd2; v.e.ret = 1;
    end
    if (is_fn) begin v.e.pcw = 1; v.e.ret = 1; end
    rq.push_back(v);
    if (is_ld | is_st) begin
      for (int k = 0; k <= mw; k++) begin
        v.mr = (k == mw); v.nm = "rnd_mem";
        v.e = o(ST_MEM, 1, is_st, 0, 0, is_st & (k == mw), 0, 0, 0, sa, sb, op,
                is_st & (k == mw), 0, 0);
        rq.push_back(v);
      end
    end
    if (is_r | is_i | is_aui | is_lui | is_ld) begin
      v.mr = 1'($urandom); v.nm = "rnd_wb";
      v.e = o(ST_WB, 0, 0, 0, 0, 1, 0, 1, is_ld ? 2'd1 : (is_lui ? 2'd3 : 2'd0),
              sa, sb, op, 1, 0, 0);
      rq.push_back(v);
    end
  endtask

  logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F};

  initial begin
    // ---- vector table: reset, ALU, branches, jumps, LUI ----
    addv(0, ADDI, 0, 0, o(ST_IDLE,   0,0,0,0, 0,0, 0,0, 0,0,0, 0, 0,0), "reset_idle");
    addv(1, ADDI, 0, 0, o(ST_IDLE,   0,0,0,0, 0,0, 0,0, 0,0,0, 0, 0,0), "idle_hold");
    addv(1, ADDI, 1, 0, o(ST_FETCH,  1,0,1,1, 0,0, 0,0, 0,0,0, 0, 0,0), "addi_fetch");
    addv(1, ADDI, 0, 0, o(ST_DECODE, 0,0,0,0, 0,0, 0,0, 0,0,0, 0, 0,0), "addi_decode");
    addv(1, ADDI, 0, 0, o(ST_EXEC,   0,0,0,0, 0,0, 0,0, 0,1,1, 0, 0,0), "addi_exec");
    addv(1, ADDI, 0, 0, o(ST_WB,     0,0,0,0, 1,0, 1,0, 0,1,1, 1, 0,0), "addi_wb");
    addv(1, BEQ,  1, 1, o(ST_FETCH,  1,0,1,1, 0,0, 0,0, 0,0,0, 0, 0,0), "beq_t_fetch");
    addv(1, BEQ,  0, 1, o(ST_DECODE, 0,0,0,0, 0,0, 0,0, 0,0,0, 0, 0,0), "beq_t_decode");
    addv(1, BEQ,  0, 1, o(ST_EXEC,   0,0,0,0, 1,1, 0,0, 0,0,2, 1, 0,0), "beq_t_exec");
    addv(1, BEQ,  1, 0, o(ST_FETCH,  1,0,1,1, 0,0, 0,0, 0,0,0, 0, 0,0), "beq_n_fetch");
    addv(1, BEQ,  0, 0, o(ST_DECODE, 0,0,0,0, 0,0, 0,0, 0,0,0, 0, 0,0), "beq_n_decode");
    addv(1, BEQ,  0, 0, o(ST_EXEC,   0,0,0,0, 1,0, 0,0, 0,0,2, 1, 0,0), "beq_n_exec");
    addv(1, JALR, 1, 0, o(ST_FETCH,  1,0,1,1, 0,0, 0,0, 0,0,0, 0, 0,0), "jalr_fetch");
    addv(1, JALR, 0, 0, o(ST_DECODE, 0,0,0,0, 0,0, 0,0, 0,0,0, 0, 0,0), "jalr_decode");
    addv(1, JALR, 0, 0, o(ST_EXEC,   0,0,0,0, 1,2, 1,2, 0,1,0, 1, 0,0), "jalr_exec");
    addv(1, LUI,  1, 0, o(ST_FETCH,  1,0,1,1, 0,0, 0,0, 0,0,0, 0, 0,0), "lui_fetch");
    addv(1, LUI,  0, 0, o(ST_DECODE, 0,0,0,0, 0,0, 0,0, 0,0,0, 0, 0,0), "lui_decode");
    addv(1, LUI,  0, 0, o(ST_EXEC,   0,0,0,0, 0,0, 0,0, 0,0,0, 0, 0,0), "lui_exec");
    addv(1, LUI,  0, 0, o(ST_WB,     0,0,0,0, 1,0, 1,3, 0,0,0, 1, 0,0), "lui_wb");
    addv(1, JAL,  1, 0, o(ST_FETCH,  1,0,1,1, 0,0, 0,0, 0,0,0, 0, 0,0), "jal_fetch");
    addv(1, JAL,  0, 0, o(ST_DECODE, 0,0,0,0, 0,0, 0,0, 0,0,0, 0, 0,0), "jal_decode");
    addv(1, JAL,  0, 0, o(ST_EXEC,   0,0,0,0, 1,1, 1,2, 0,0,0, 1, 0,0), "jal_exec");
    addv(1, ADDI, 0, 0, o(ST_FETCH,  1,0,1,0, 0,0, 0,0, 0,0,0, 0, 0,0), "fetch_wait");
    foreach (tv[k]) step(tv[k].r, tv[k].i, tv[k].mr, tv[k].bt, tv[k].e, tv[k].nm);

    // ---- LW with three MEM wait cycles: 8 cycles total ----
    rst_pulse();
    step(1, LW, 0, 0, o(ST_IDLE,   0,0,0,0, 0,0, 0,0, 0,0,0, 0, 0,0), "lw_idle");
    step(1, LW, 1, 0, o(ST_FETCH,  1,0,1,1, 0,0, 0,0, 0,0,0, 0, 0,0), "lw_fetch");
    step(1, LW, 0, 0, o(ST_DECODE, 0,0,0,0, 0,0, 0,0, 0,0,0, 0, 0,0), "lw_decode");
    step(1, LW, 0, 0, o(ST_EXEC,   0,0,0,0, 0,0, 0,0, 0,1,0, 0, 0,0), "lw_exec");
    for (int k = 0; k < 4; k++)
      step(1, LW, (k == 3), 0, o(ST_MEM, 1,0,0,0, 0,0, 0,0, 0,1,0, 0, 0,0), "lw_mem");
    step(1, LW, 0, 0, o(ST_WB,     0,0,0,0, 1,0, 1,1, 0,1,0, 1, 0,0), "lw_wb");
    step(1, LW, 0, 0, o(ST_FETCH,  1,0,1,0, 0,0, 0,0, 0,0,0, 0, 0,0), "lw_next_fetch");

    // ---- illegal opcode: sticky trap, cleared only by reset ----
    rst_pulse();
    step(1, BAD, 0, 0, o(ST_IDLE,   0,0,0,0, 0,0, 0,0, 0,0,0, 0, 0,0), "ill_idle");
    step(1, BAD, 1, 0, o(ST_FETCH,  1,0,1,1, 0,0, 0,0, 0,0,0, 0, 0,0), "ill_fetch");
    step(1, BAD, 0, 0, o(ST_DECODE, 0,0,0,0, 0,0, 0,0, 0,0,0, 0, 0,0), "ill_decode");
    for (int k = 0; k < 20; k++)
      step(1, BAD, 1'($urandom), 1'($urandom),
           o(ST_TRAP, 0,0,0,0, 0,0, 0,0, 0,0,0, 0, 1,0), "ill_trap_sticky");
    rst_pulse();
    step(1, ADDI, 0, 0, o(ST_IDLE,  0,0,0,0, 0,0, 0,0, 0,0,0, 0, 0,0), "ill_reset_idle");
    step(1, ADDI, 0, 0, o(ST_FETCH, 1,0,1,0, 0,0, 0,0, 0,0,0, 0, 0,0), "ill_reset_fetch");

    // ---- fetch timeout after 4 waiting cycles; ready on the 4th wins ----
    rst_pulse();
    step(1, ADDI, 0, 0, o(ST_IDLE, 0,0,0,0, 0,0, 0,0, 0,0,0, 0, 0,0), "tmo_idle");
    for (int k = 0; k < 4; k++)
      step(1, ADDI, 0, 0, o(ST_FETCH, 1,0,1,0, 0,0, 0,0, 0,0,0, 0, 0,0), "tmo_fetch_wait");
    step(1, ADDI, 1, 0, o(ST_TRAP, 0,0,0,0, 0,0, 0,0, 0,0,0, 0, 0,1), "tmo_trap");
    step(1, ADDI, 1, 0, o(ST_TRAP, 0,0,0,0, 0,0, 0,0, 0,0,0, 0, 0,1), "tmo_trap_stay");
    rst_pulse();
    step(1, ADDI, 0, 0, o(ST_IDLE, 0,0,0,0, 0,0, 0,0, 0,0,0, 0, 0,0), "tmo2_idle");
    for (int k = 0; k < 4; k++)
      step(1, ADDI, (k == 3), 0, o(ST_FETCH, 1,0,1,(k == 3), 0,0, 0,0, 0,0,0, 0, 0,0),
           "tmo2_fetch");
    step(1, ADDI, 0, 0, o(ST_DECODE, 0,0,0,0, 0,0, 0,0, 0,0,0, 0, 0,0), "tmo2_decode");

    // ---- JALR, then a stalled SW interrupted by reset ----
    rst_pulse();
    step(1, JALR, 0, 0, o(ST_IDLE,   0,0,0,0, 0,0, 0,0, 0,0,0, 0, 0,0), "sw_idle");
    step(1, JALR, 1, 0, o(ST_FETCH,  1,0,1,1, 0,0, 0,0, 0,0,0, 0, 0,0), "jalr2_fetch");
    step(1, JALR, 0, 0, o(ST_DECODE, 0,0,0,0, 0,0, 0,0, 0,0,0, 0, 0,0), "jalr2_decode");
    step(1, JALR, 0, 0, o(ST_EXEC,   0,0,0,0, 1,2, 1,2, 0,1,0, 1, 0,0), "jalr2_exec");
    step(1, SW,   1, 0, o(ST_FETCH,  1,0,1,1, 0,0, 0,0, 0,0,0, 0, 0,0), "sw_fetch");
    step(1, SW,   0, 0, o(ST_DECODE, 0,0,0,0, 0,0, 0,0, 0,0,0, 0, 0,0), "sw_decode");
    step(1, SW,   0, 0, o(ST_EXEC,   0,0,0,0, 0,0, 0,0, 0,1,0, 0, 0,0), "sw_exec");
    step(1, SW,   0, 0, o(ST_MEM,    1,1,0,0, 0,0, 0,0, 0,1,0, 0, 0,0), "sw_mem_wait");
    step(1, SW,   0, 0, o(ST_MEM,    1,1,0,0, 0,0, 0,0, 0,1,0, 0, 0,0), "sw_mem_wait");
    rst_pulse();
    step(1, SW,   0, 0, o(ST_IDLE,   0,0,0,0, 0,0, 0,0, 0,0,0, 0, 0,0), "sw_reset_idle");

    // ---- random program with random wait states against the trace model ----
    for (int n = 0; n < 60; n++) begin
      logic [31:0] ri;
      ri = $urandom;
      ri[6:0] = ops[$urandom_range(0, 9)];
      plan(ri, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end
    foreach (rq[k]) step(rq[k].r, rq[k].i, rq[k].mr, rq[k].bt, rq[k].e, rq[k].nm);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
